battleship_board: RTL and testbench

Game-board storage for one player's 10x10 grid: the memory-side responder to the PicoBlaze I/O interface's RAM request signals (cursor read address, write address/enable/value). Services cursor reads with 1-cycle latency, commits writes by read-modify-write, keeps live ship/hit cell counts, provides a second read port for the display, and sweeps the board to EMPTY after reset or a new-game request.

---
 rtl/battleship_pkg.sv | 20 ++
 rtl/board_mem.sv | 28 ++
 rtl/battleship_board.sv | 168 ++++++++++++++++
 tb/tb_battleship_board.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship board: cell encoding, board size, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package battleship_pkg;

  localparam int NUM_CELLS = 100;
  localparam int CELL_W    = 2;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'd0;
  localparam logic [CELL_W-1:0] CELL_SHIP  = 2'd1;
  localparam logic [CELL_W-1:0] CELL_HIT   = 2'd2;
  localparam logic [CELL_W-1:0] CELL_MISS  = 2'd3;

  // CLEAR sweeps the board to EMPTY; READY services game writes.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } board_state_e;

endpackage

// File: rtl/board_mem.sv
// Simple dual-port cell RAM: one synchronous write port, one synchronous read-first read port.
// Latency: read address sampled at edge N, data valid after edge N; write lands at the same edge.
// Backpressure: none, accepts a read and a write every cycle; contents are not reset.
module board_mem
  import battleship_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int MAW   = 7
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [MAW-1:0]    waddr_i,
  input  logic [CELL_W-1:0] wdata_i,
  input  logic [MAW-1:0]    raddr_i,
  output logic [CELL_W-1:0] rdata_o
);

  logic [CELL_W-1:0] mem_q [DEPTH];

  // Read-first: a same-edge write is not visible to the read issued at that edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/battleship_board.sv
// One player's 10x10 board: cursor/display reads, read-modify-write cell updates, live SHIP/HIT counts.
// Latency: reads 1 cycle; a write sampled at edge N commits (cell and counters) at edge N+1.
// Backpressure: none; writes are dropped while clearing (ready=0) or when out of range.
module battleship_board
  import battleship_pkg::*;
#(
  parameter int CELLS = NUM_CELLS,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_game,
  input  logic [AW-1:0]     cursor,
  output logic [CELL_W-1:0] rd_data,
  input  logic [AW-1:0]     wr_addr,
  input  logic              wr_en,
  input  logic [CELL_W-1:0] wr_val,
  input  logic [6:0]        disp_addr,
  output logic [CELL_W-1:0] disp_data,
  input  logic              placement_done,
  output logic              ready,
  output logic [6:0]        ship_cnt,
  output logic [6:0]        hit_cnt,
  output logic              all_sunk
);

  localparam logic [AW-1:0] CELLS_A = AW'(CELLS);
  localparam logic [6:0]    CELLS_7 = 7'(CELLS);
  localparam logic [6:0]    LAST_7  = 7'(CELLS - 1);

  board_state_e state_q, state_d;
  logic [6:0]   clr_ptr_q, clr_ptr_d;
  logic         sweep_we;

  logic              s1_vld_q;
  logic [6:0]        s1_addr_q;
  logic [CELL_W-1:0] s1_val_q;
  logic              s1_fwd_q;
  logic [CELL_W-1:0] s1_fwd_val_q;
  logic              wr_take;
  logic [CELL_W-1:0] old_val;

  logic              mem_we;
  logic [6:0]        mem_waddr;
  logic [CELL_W-1:0] mem_wdata;
  logic [CELL_W-1:0] cur_rdata, disp_rdata, rmw_rdata;

  logic              rd_ok_q, disp_ok_q;
  logic [6:0]        ship_q, ship_d, hit_q, hit_d;
  logic              all_sunk_q, all_sunk_d;

  // FSM state register and clear pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: new_game always restarts the sweep; sweep ends after the last cell.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (new_game) begin
      state_d   = ST_CLEAR;
      clr_ptr_d = '0;
    end else if (state_q == ST_CLEAR) begin
      if (clr_ptr_q == LAST_7) begin
        state_d   = ST_READY;
        clr_ptr_d = '0;
      end else begin
        clr_ptr_d = clr_ptr_q + 7'd1;
      end
    end
  end

  // FSM outputs: sweep owns the write port while clearing.
  always_comb begin
    sweep_we = (state_q == ST_CLEAR);
    ready    = (state_q == ST_READY);
  end

  // Stage 0 acceptance; a write committing this edge to the same cell is the true old value.
  assign wr_take = ready && wr_en && (wr_addr < CELLS_A) && !new_game;
  assign old_val = s1_fwd_q ? s1_fwd_val_q : rmw_rdata;

  // Write pipeline register (stage 1) with forwarding capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q     <= 1'b0;
      s1_addr_q    <= '0;
      s1_val_q     <= CELL_EMPTY;
      s1_fwd_q     <= 1'b0;
      s1_fwd_val_q <= CELL_EMPTY;
    end else begin
      s1_vld_q <= wr_take;
      if (wr_take) begin
        s1_addr_q    <= wr_addr[6:0];
        s1_val_q     <= wr_val;
        s1_fwd_q     <= s1_vld_q && (s1_addr_q == wr_addr[6:0]);
        s1_fwd_val_q <= s1_val_q;
      end
    end
  end

  // Shared write port: sweep writes EMPTY, otherwise stage 1 commits unless new_game discards it.
  always_comb begin
    mem_we    = sweep_we || (s1_vld_q && !new_game);
    mem_waddr = sweep_we ? clr_ptr_q : s1_addr_q;
    mem_wdata = sweep_we ? CELL_EMPTY : s1_val_q;
  end

  board_mem u_mem_cursor (
    .clk(clk), .we_i(mem_we), .waddr_i(mem_waddr), .wdata_i(mem_wdata),
    .raddr_i(cursor[6:0]), .rdata_o(cur_rdata)
  );

  board_mem u_mem_disp (
    .clk(clk), .we_i(mem_we), .waddr_i(mem_waddr), .wdata_i(mem_wdata),
    .raddr_i(disp_addr), .rdata_o(disp_rdata)
  );

  board_mem u_mem_rmw (
    .clk(clk), .we_i(mem_we), .waddr_i(mem_waddr), .wdata_i(mem_wdata),
    .raddr_i(wr_addr[6:0]), .rdata_o(rmw_rdata)
  );

  // Counter update from the committing write's old/new values; new_game zeroes them.
  always_comb begin
    ship_d     = ship_q;
    hit_d      = hit_q;
    all_sunk_d = placement_done && ready && (ship_q == 7'd0) && (hit_q != 7'd0);
    if (new_game) begin
      ship_d = '0;
      hit_d  = '0;
    end else if (s1_vld_q) begin
      ship_d = ship_q + {6'd0, s1_val_q == CELL_SHIP} - {6'd0, old_val == CELL_SHIP};
      hit_d  = hit_q  + {6'd0, s1_val_q == CELL_HIT}  - {6'd0, old_val == CELL_HIT};
    end
  end

  // Counters, all_sunk, and read-valid qualifiers (blank reads while clearing or out of range).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ship_q     <= '0;
      hit_q      <= '0;
      all_sunk_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      disp_ok_q  <= 1'b0;
    end else begin
      ship_q     <= ship_d;
      hit_q      <= hit_d;
      all_sunk_q <= all_sunk_d;
      rd_ok_q    <= ready && (cursor < CELLS_A);
      disp_ok_q  <= ready && (disp_addr < CELLS_7);
    end
  end

  assign rd_data   = rd_ok_q   ? cur_rdata  : CELL_EMPTY;
  assign disp_data = disp_ok_q ? disp_rdata : CELL_EMPTY;
  assign ship_cnt  = ship_q;
  assign hit_cnt   = hit_q;
  assign all_sunk  = all_sunk_q;

endmodule

// File: tb/tb_battleship_board.sv
// Bench for battleship_board: cell-array model checked every cycle plus directed literal checks.
// Latency: model mirrors the visible timing (1-cycle reads, commit one edge after capture).
// Backpressure: none; stimulus drives on the falling edge.
module tb_battleship_board;
  import battleship_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       new_game = 1'b0;
  logic [7:0] cursor = 8'd0;
  logic [1:0] rd_data;
  logic [7:0] wr_addr = 8'd0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_val = 2'd0;
  logic [6:0] disp_addr = 7'd0;
  logic [1:0] disp_data;
  logic       placement_done = 1'b0;
  logic       ready;
  logic [6:0] ship_cnt, hit_cnt;
  logic       all_sunk;

  int errors = 0;
  int checks = 0;

  battleship_board #(.CELLS(100), .AW(8)) dut (
    .clk(clk), .reset_n(reset_n), .new_game(new_game),
    .cursor(cursor), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_val(wr_val),
    .disp_addr(disp_addr), .disp_data(disp_data),
    .placement_done(placement_done), .ready(ready),
    .ship_cnt(ship_cnt), .hit_cnt(hit_cnt), .all_sunk(all_sunk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mem [100];
  bit m_ready = 0;
  int m_sweep = 0;
  bit m_pend = 0;
  int m_pend_addr = 0;
  int m_pend_val = 0;
  int e_rd = 0;
  int e_disp = 0;
  bit e_sunk = 0;
  int n_rd, n_disp;
  bit n_sunk, take;

  function automatic int count_of(input int v);
    int c = 0;
    for (int i = 0; i < 100; i++) if (mem[i] == v) c++;
    return c;
  endfunction

  initial begin
    for (int i = 0; i < 100; i++) mem[i] = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_ready = 0; m_sweep = 0; m_pend = 0;
        e_rd = 0; e_disp = 0; e_sunk = 0;
        for (int i = 0; i < 100; i++) mem[i] = 0;
      end else begin
        n_rd   = (m_ready && cursor < 8'd100) ? mem[cursor] : 0;
        n_disp = (m_ready && disp_addr < 7'd100) ? mem[disp_addr] : 0;
        n_sunk = placement_done && m_ready && count_of(1) == 0 && count_of(2) != 0;
        if (new_game) begin
          m_ready = 0; m_sweep = 0; m_pend = 0;
          for (int i = 0; i < 100; i++) mem[i] = 0;
        end else begin
          take = m_ready && wr_en && (wr_addr < 8'd100);
          if (m_pend) mem[m_pend_addr] = m_pend_val;
          m_pend = take;
          if (take) begin
            m_pend_addr = int'(wr_addr);
            m_pend_val  = int'(wr_val);
          end
          if (!m_ready) begin
            m_sweep++;
            if (m_sweep == 100) m_ready = 1;
          end
        end
        e_rd = n_rd; e_disp = n_disp; e_sunk = n_sunk;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_rd_data", int'(rd_data), e_rd);
      chk("model_disp_data", int'(disp_data), e_disp);
      chk("model_ready", int'(ready), int'(m_ready));
      chk("model_ship_cnt", int'(ship_cnt), count_of(1));
      chk("model_hit_cnt", int'(hit_cnt), count_of(2));
      chk("model_all_sunk", int'(all_sunk), int'(e_sunk));
      chk("cnt_bound", int'(ship_cnt + hit_cnt <= 7'd100), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [7:0] a, input logic [1:0] v);
    wr_addr = a; wr_val = v; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, 100);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready), 0);
    chk("rst_ship", int'(ship_cnt), 0);
    chk("rst_hit", int'(hit_cnt), 0);
    chk("rst_sunk", int'(all_sunk), 0);
    chk("rst_rd", int'(rd_data), 0);

    // Release reset with a write held; it must be ignored during the sweep.
    wr_addr = 8'd5; wr_val = CELL_SHIP; wr_en = 1'b1;
    reset_n = 1'b1;
    wait_ready("sweep_len_reset");
    wr_en = 1'b0;
    chk("sweep_ship", int'(ship_cnt), 0);

    for (int i = 0; i < 100; i++) begin
      cursor = 8'(i); disp_addr = 7'(99 - i);
      @(negedge clk);
      chk("swept_cell", int'(rd_data), 0);
    end

    // Three SHIP cells.
    wr(8'd5, CELL_SHIP); wr(8'd6, CELL_SHIP); wr(8'd7, CELL_SHIP);
    cursor = 8'd6;
    @(negedge clk);
    chk("read_ship6", int'(rd_data), 1);
    chk("ship3", int'(ship_cnt), 3);

    // Level-held identical write is idempotent.
    wr_addr = 8'd6; wr_val = CELL_SHIP; wr_en = 1'b1;
    repeat (20) @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    chk("held_ship3", int'(ship_cnt), 3);

    // Back-to-back writes to one cell exercise forwarding.
    wr(8'd6, CELL_HIT); wr(8'd6, CELL_MISS);
    @(negedge clk);
    chk("fwd_ship2", int'(ship_cnt), 2);
    chk("fwd_hit0", int'(hit_cnt), 0);
    @(negedge clk);
    chk("fwd_cell6", int'(rd_data), 3);

    // Sink everything with placement done; all_sunk lags counters by one cycle.
    wr(8'd6, CELL_SHIP);
    placement_done = 1'b1;
    wr(8'd5, CELL_HIT); wr(8'd7, CELL_HIT);
    @(negedge clk);
    chk("sink_ship1", int'(ship_cnt), 1);
    chk("sink_hit2", int'(hit_cnt), 2);
    wr(8'd6, CELL_HIT);
    @(negedge clk);
    chk("sunk_ship0", int'(ship_cnt), 0);
    chk("sunk_hit3", int'(hit_cnt), 3);
    chk("sunk_lag", int'(all_sunk), 0);
    @(negedge clk);
    chk("sunk_set", int'(all_sunk), 1);

    // Out-of-range writes and reads.
    wr(8'hFF, CELL_SHIP); wr(8'd100, CELL_SHIP);
    repeat (2) @(negedge clk);
    chk("oob_ship", int'(ship_cnt), 0);
    chk("oob_hit", int'(hit_cnt), 3);
    cursor = 8'hFF; disp_addr = 7'd120;
    @(negedge clk);
    chk("oob_rd", int'(rd_data), 0);
    chk("oob_disp", int'(disp_data), 0);

    // Last valid cell.
    cursor = 8'd99; disp_addr = 7'd99;
    wr(8'd99, CELL_SHIP);
    @(negedge clk);
    chk("last_ship1", int'(ship_cnt), 1);
    @(negedge clk);
    chk("last_rd", int'(rd_data), 1);
    chk("last_disp", int'(disp_data), 1);
    placement_done = 1'b0;

    // new_game the cycle after a SHIP write: the write is lost.
    wr(8'd10, CELL_SHIP);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("ng_ship", int'(ship_cnt), 0);
    chk("ng_hit", int'(hit_cnt), 0);
    chk("ng_ready", int'(ready), 0);
    wait_ready("sweep_len_newgame");
    cursor = 8'd10;
    repeat (2) @(negedge clk);
    chk("ng_cell10", int'(rd_data), 0);

    // Reset with a write in flight, then reset mid-sweep.
    wr(8'd20, CELL_SHIP); wr(8'd21, CELL_HIT);
    @(negedge clk);
    chk("pre_rst_ship", int'(ship_cnt), 1);
    chk("pre_rst_hit", int'(hit_cnt), 1);
    wr(8'd22, CELL_SHIP);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_ship", int'(ship_cnt), 0);
    chk("rst_mid_hit", int'(hit_cnt), 0);
    chk("rst_mid_ready", int'(ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rst_sweep_ready", int'(ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready("sweep_len_restart");
    cursor = 8'd22;
    repeat (2) @(negedge clk);
    chk("rst_cell22", int'(rd_data), 0);
    chk("rst_final_ship", int'(ship_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
